// File: rtl/diffamp_cal_ctrl.sv
// Diff-amp offset calibration: SAR search on trim with settle waits.
// Define DIFFAMP_CAL_MAJ3_EN for a 3-sample majority vote per bit.
module diffamp_cal_ctrl #(
  parameter int TRIM_W     = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cal_start,
  input  logic              cal_abort,
  input  logic              cmp_out,
  output logic              bias_en,
  output logic              short_en,
  output logic [TRIM_W-1:0] trim,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_fail
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int IW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
`ifdef DIFFAMP_CAL_MAJ3_EN
  localparam int NSMP = 3;
`else
  localparam int NSMP = 1;
`endif

  typedef enum logic [2:0] {
    IDLE, BIAS, WAIT, SAMPLE, DONE
  } state_t;

  state_t            state, nstate;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [TRIM_W-1:0] saved;
  logic [TRIM_W-1:0] trim_smp;
  logic              ok;
  logic              sy1, cmp_s;
  logic              settle_hit, samp_last, dec;

`ifdef DIFFAMP_CAL_MAJ3_EN
  logic [1:0] smp;
  assign dec = (smp[0] & smp[1]) | (smp[0] & cmp_s) | (smp[1] & cmp_s);
`else
  assign dec = cmp_s;
`endif

  assign settle_hit = (cnt == CW'(SETTLE_CYC - 1));
  assign samp_last  = (cnt == CW'(NSMP - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sy1   <= 1'b0;
      cmp_s <= 1'b0;
    end else begin
      sy1   <= cmp_out;
      cmp_s <= sy1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:   if (cal_start) nstate = BIAS;
      BIAS: begin
        if (cal_abort)       nstate = IDLE;
        else if (settle_hit) nstate = WAIT;
      end
      WAIT: begin
        if (cal_abort)       nstate = IDLE;
        else if (settle_hit) nstate = SAMPLE;
      end
      SAMPLE: begin
        if (cal_abort)      nstate = IDLE;
        else if (samp_last) nstate = (idx == '0) ? DONE : WAIT;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Resolve the current bit, then trial-set the next lower one
  always_comb begin
    trim_smp = trim;
    if (!dec) trim_smp[idx] = 1'b0;
    if (idx != '0) trim_smp[idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      idx      <= '0;
      trim     <= '0;
      saved    <= '0;
      ok       <= 1'b0;
      cal_fail <= 1'b0;
`ifdef DIFFAMP_CAL_MAJ3_EN
      smp      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (cal_start) begin
          cnt      <= '0;
          cal_fail <= 1'b0;
          trim     <= '0;
        end
        BIAS: begin
          if (cal_abort) begin
            trim <= saved;
          end else if (settle_hit) begin
            idx  <= IW'(TRIM_W - 1);
            trim <= TRIM_W'(1) << (TRIM_W - 1);
            cnt  <= '0;
          end else begin
            cnt  <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (cal_abort)       trim <= saved;
          else if (settle_hit) cnt  <= '0;
          else                 cnt  <= cnt + 1'b1;
        end
        SAMPLE: begin
          if (cal_abort) begin
            trim <= saved;
          end else if (samp_last) begin
            trim <= trim_smp;
            cnt  <= '0;
            if (idx != '0) idx <= idx - 1'b1;
          end else begin
            cnt  <= cnt + 1'b1;
`ifdef DIFFAMP_CAL_MAJ3_EN
            smp[cnt[0]] <= cmp_s;
`endif
          end
        end
        DONE: begin
          saved    <= trim;
          cal_fail <= (trim == '0) || (&trim);
          ok       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cal_busy = (state == BIAS) || (state == WAIT) || (state == SAMPLE);
    short_en = cal_busy;
    cal_done = (state == DONE);
    bias_en  = cal_busy || cal_done || ok;
  end

endmodule

// File: tb/tb_diffamp_cal_ctrl.sv
// Directed bench for diffamp_cal_ctrl with a threshold amplifier model.
// Build with DIFFAMP_CAL_MAJ3_EN to cover the majority-vote variant.
module tb_diffamp_cal_ctrl;

`ifdef DIFFAMP_CAL_MAJ3_EN
  localparam int LAT = 40;
  localparam int PB  = 7;
`else
  localparam int LAT = 30;
  localparam int PB  = 5;
`endif

  logic       clk = 1'b0;
  logic       rstn, cal_start, cal_abort, cmp_out;
  logic       bias_en, short_en, cal_busy, cal_done, cal_fail;
  logic [4:0] trim;

  int   mode, target, cyc, errs, checks;
  logic glitch, glitch_en;
  int   dn, dat, bad;
  logic [31:0] snap;

  diffamp_cal_ctrl #(.TRIM_W(5), .SETTLE_CYC(4)) dut (
    .clk(clk), .rstn(rstn), .cal_start(cal_start),
    .cal_abort(cal_abort), .cmp_out(cmp_out),
    .bias_en(bias_en), .short_en(short_en), .trim(trim),
    .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail)
  );

  always #5 clk = ~clk;

  // mode 0: threshold at target, 1: stuck low, 2: stuck high
  always_comb begin
    cmp_out = glitch ^ ((mode == 1) ? 1'b0 :
                        (mode == 2) ? 1'b1 :
                        (int'(trim) <= target));
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Glitch cmp_out two cycles ahead so the synced copy flips mid-window
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    glitch = glitch_en && cyc >= 8 && ((cyc - 8) % PB == 0);
  endtask

  task automatic start();
    cal_start = 1'b1;
    cyc = 0;
    tick();
    cal_start = 1'b0;
  endtask

  task automatic run(input int abort_at, input int start_at,
                     output int n, output int at, output int bb,
                     output logic [31:0] sn);
    n  = 0;
    at = 0;
    bb = 0;
    sn = '0;
    while (cyc < LAT + 4) begin
      if (cal_done) begin
        n++;
        at = cyc;
      end
      if (cal_busy !== (cyc < LAT && (abort_at == 0 || cyc <= abort_at)))
        bb++;
      if (short_en !== cal_busy) bb++;
      if (cyc == abort_at + 1)
        sn = {24'd0, cal_busy, short_en, bias_en, trim};
      if (cyc == abort_at) cal_abort = 1'b1;
      if (cyc == start_at) cal_start = 1'b1;
      tick();
      cal_abort = 1'b0;
      cal_start = 1'b0;
    end
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0;
    rstn = 1'b0; cal_start = 1'b0; cal_abort = 1'b0;
    mode = 0; target = 19; glitch = 1'b0; glitch_en = 1'b0;
    #12;
    chk("reset", {bias_en, short_en, trim, cal_busy, cal_done, cal_fail}, 0);
    @(negedge clk) rstn = 1'b1;
    tick();

    // target 19
    start();
    run(0, 0, dn, dat, bad, snap);
    chk("t19_busy", bad, 0);
    chk("t19_ndone", dn, 1);
    chk("t19_lat", dat, LAT);
    chk("t19_trim", trim, 19);
    chk("t19_fail", cal_fail, 0);
    chk("t19_en", {bias_en, short_en}, 2'b10);

    // stuck low -> rail 0, then target 7 clears fail
    mode = 1;
    start();
    run(0, 0, dn, dat, bad, snap);
    chk("lo_trim", trim, 0);
    chk("lo_fail", cal_fail, 1);
    mode = 0; target = 7;
    start();
    chk("t7_failclr", cal_fail, 0);
    run(0, 0, dn, dat, bad, snap);
    chk("t7_trim", trim, 7);
    chk("t7_fail", cal_fail, 0);

    // stuck high -> rail 31, start while busy ignored
    mode = 2;
    start();
    run(0, 10, dn, dat, bad, snap);
    chk("hi_trim", trim, 31);
    chk("hi_fail", cal_fail, 1);
    chk("hi_ndone", dn, 1);
    chk("hi_busy", bad, 0);

    // good run then abort at cycle 12
    mode = 0; target = 19;
    start();
    run(0, 0, dn, dat, bad, snap);
    chk("ab_pre", trim, 19);
    start();
    run(12, 0, dn, dat, bad, snap);
    chk("ab_snap", snap, {24'd0, 3'b001, 5'd19});
    chk("ab_ndone", dn, 0);
    chk("ab_busy", bad, 0);
    chk("ab_trim", trim, 19);
    chk("ab_fail", cal_fail, 0);

    // async reset mid-WAIT
    start();
    while (cyc < 15) tick();
    #2 rstn = 1'b0;
    #1;
    chk("arst", {bias_en, short_en, trim, cal_busy, cal_done, cal_fail}, 0);
    @(negedge clk) rstn = 1'b1;
    tick();
    chk("arst_idle", {bias_en, trim, cal_busy}, 0);

`ifdef DIFFAMP_CAL_MAJ3_EN
    glitch_en = 1'b1;
    start();
    run(0, 0, dn, dat, bad, snap);
    glitch_en = 1'b0;
    glitch = 1'b0;
    chk("maj_trim", trim, 19);
    chk("maj_lat", dat, 40);
    chk("maj_ndone", dn, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/diffamp_cal_ctrl.md
Name: diffamp_cal_ctrl

Overview:
Offset-calibration sequencer for the differential amplifier/comparator cell. It enables the tail bias and shorts the amplifier inputs. It then runs a successive-approximation search on a trim code while watching the amplifier output, and leaves the final trim code applied. It sits between the digital control domain and the analog amplifier macro.

Parameters:
TRIM_W, 5, width of trim code driven to the amplifier's trim DAC (range 2..8)
SETTLE_CYC, 4, clock cycles waited after every bias/trim change before sampling (minimum 3, which covers the 2-flop synchronizer)

Ports:
clk  input  1  system clock; all state on rising edge
rstn  input  1  asynchronous active-low reset
cal_start  input  1  request calibration; sampled only in IDLE
cal_abort  input  1  synchronous abort; valid in any busy state
cmp_out  input  1  amplifier output (asynchronous); 1 = trim code at/below offset point
bias_en  output  1  drives amplifier tail-current gate
short_en  output  1  shorts amplifier differential inputs during calibration
trim  output  TRIM_W  trim code to amplifier DAC
cal_busy  output  1  high while a calibration is in progress
cal_done  output  1  one-cycle pulse at end of a completed calibration
cal_fail  output  1  result pinned at a rail; held until next accepted cal_start

Behaviour:
- Reset (rstn=0, immediate, asynchronous): state=IDLE; bias_en=0, short_en=0, trim=0, saved_trim=0, cal_busy=0, cal_done=0, cal_fail=0; sync flops=0.
- cmp_out passes through a 2-flop synchronizer (cmp_s). Only cmp_s is used.
- States: IDLE, BIAS, WAIT, SAMPLE, DONE.
- IDLE: bias_en=0, short_en=0, trim holds last result. cal_start=1 at edge E0 -> BIAS. At E0 also: cnt=0, cal_fail cleared, trim=0.
- BIAS: bias_en=1, short_en=1, cal_busy=1. Stays for SETTLE_CYC cycles. On exit: idx=TRIM_W-1, trim=1<<(TRIM_W-1), cnt=0 -> WAIT.
- WAIT: stays for SETTLE_CYC cycles -> SAMPLE.
- SAMPLE (1 cycle): if cmp_s=0, clear trim[idx].
  - If idx=0 -> DONE.
  - Otherwise idx=idx-1, set trim[idx-1], cnt=0 -> WAIT.
- DONE (1 cycle): cal_done=1, cal_busy=0, bias_en=1, short_en=0. saved_trim=trim. cal_fail=1 if trim is all-0 or all-1. Next state IDLE.
- bias_en stays 1 after the first successful calibration (amplifier remains operational). It returns to 0 only on reset or abort-before-first-success.
- Latency: DONE occurs at E0 + 1 + SETTLE_CYC + TRIM_W*(SETTLE_CYC+1) cycles. For defaults that is cycle 30.
- cal_start while busy: ignored, no queuing.
- cal_abort in BIAS/WAIT/SAMPLE: next state IDLE; trim=saved_trim; short_en=0; cal_busy=0; no cal_done; cal_fail unchanged (0). cal_abort has priority over SAMPLE updates on the same edge.
- cal_abort in IDLE or DONE: no effect.
- cal_start and cal_abort both high in IDLE: start wins.
- Counter width is clog2(SETTLE_CYC+1); no wrap-around is possible.

Optional Feature:
DIFFAMP_CAL_MAJ3_EN
- Defined: SAMPLE lasts 3 cycles and takes cmp_s on each. The bit decision is the majority of the 3 samples, applied on the third cycle. Per-bit time becomes SETTLE_CYC+3; DONE occurs at E0 + 1 + SETTLE_CYC + TRIM_W*(SETTLE_CYC+3) (cycle 40 for defaults).
- Undefined: single-sample decision as specified above.

Test Plan:
- Defaults, amplifier model cmp_out=(trim<=19), pulse cal_start -> cal_busy high cycles 1..29, cal_done pulse at cycle 30, trim=5'd19, cal_fail=0, bias_en=1, short_en=0.
- Model cmp_out=0 always -> trim=0, cal_fail=1; then a second run with target 7 -> trim=7, cal_fail cleared at start.
- Model cmp_out=1 always -> trim=5'd31, cal_fail=1. Assert cal_start during cycle 10 -> ignored, single cal_done.
- After a good run (trim=19), start a new run and assert cal_abort at cycle 12 -> IDLE next cycle, trim=19, no cal_done, short_en=0.
- Drop rstn mid-WAIT at cycle 15 -> all outputs 0 without waiting for a clock edge; after release, IDLE with trim=0.
- With DIFFAMP_CAL_MAJ3_EN, target 19 and cmp_out glitched for 1 cycle inside each SAMPLE window -> trim=19, cal_done at cycle 40.
